// File: rtl/cache_pkg.sv
// Shared constants and types for the instruction-cache status array.
package cache_pkg;
   localparam int NUM_BLOCKS    = 4;
   localparam int SA_DATA_WIDTH = 8;
   localparam int USE_BIT_IDX   = 0;
   localparam int VALID_BIT_IDX = 1;

   localparam logic [1:0] SA_OP_TOUCH = 2'b00;
   localparam logic [1:0] SA_OP_FILL  = 2'b01;
   localparam logic [1:0] SA_OP_INVAL = 2'b10;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } sa_state_e;
endpackage

// File: rtl/status_update_logic.sv
// Combinational next-status for one set: applies TOUCH/FILL/INVAL to masked blocks, then saturation.
module status_update_logic
   import cache_pkg::*;
(
   input  logic [SA_DATA_WIDTH-1:0] old_data,
   input  logic [NUM_BLOCKS-1:0]    mask,
   input  logic [1:0]               op,
   output logic [SA_DATA_WIDTH-1:0] new_data
);
   logic [NUM_BLOCKS-1:0] vld_b;
   logic [NUM_BLOCKS-1:0] use_b;

   always_comb begin
      vld_b    = '0;
      use_b    = '0;
      new_data = '0;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         vld_b[b] = old_data[b*2+VALID_BIT_IDX];
         use_b[b] = old_data[b*2+USE_BIT_IDX];
         if (mask[b]) begin
            case (op)
               SA_OP_TOUCH: use_b[b] = 1'b1;
               SA_OP_FILL:  begin vld_b[b] = 1'b1; use_b[b] = 1'b1; end
               SA_OP_INVAL: begin vld_b[b] = 1'b0; use_b[b] = 1'b0; end
               default:     ;
            endcase
         end
      end
      // All-used after a touch/fill: keep only the just-touched blocks marked
      if ((op == SA_OP_TOUCH || op == SA_OP_FILL) && (|mask) && (&use_b))
         use_b = use_b & mask;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         new_data[b*2+VALID_BIT_IDX] = vld_b[b];
         new_data[b*2+USE_BIT_IDX]   = use_b[b];
      end
   end
endmodule

// File: rtl/status_array.sv
// Per-set valid/use storage with registered read, update path and a one-set-per-cycle flush.
// STATUS_ARRAY_BYPASS_EN: same-cycle same-index read returns the post-update value.
module status_array
   import cache_pkg::*;
#(
   parameter  int NUM_SETS = 64,
   localparam int IDX_W    = $clog2(NUM_SETS)
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_rd_valid,
   input  logic [IDX_W-1:0]         i_rd_index,
   output logic [SA_DATA_WIDTH-1:0] o_sa_data,
   output logic                     o_sa_data_valid,
   input  logic                     i_upd_valid,
   input  logic [IDX_W-1:0]         i_upd_index,
   input  logic [NUM_BLOCKS-1:0]    i_upd_mask,
   input  logic [1:0]               i_upd_op,
   input  logic                     i_flush,
   output logic                     o_ready
);
   sa_state_e                               state, state_nxt;
   logic [IDX_W-1:0]                        flush_cnt;
   logic [NUM_SETS-1:0][SA_DATA_WIDTH-1:0] entry;
   logic [SA_DATA_WIDTH-1:0]                upd_new;
   logic                                    rd_acc, upd_acc, rd_hit;
   logic [1:0]                              vld_pipe;

   assign rd_acc  = i_rd_valid  & o_ready;
   assign upd_acc = i_upd_valid & o_ready;

   status_update_logic u_upd (
      .old_data (entry[i_upd_index]),
      .mask     (i_upd_mask),
      .op       (i_upd_op),
      .new_data (upd_new)
   );

`ifdef STATUS_ARRAY_BYPASS_EN
   assign rd_hit = upd_acc && (i_upd_index == i_rd_index);
`else
   assign rd_hit = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state     <= ST_IDLE;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= (state == ST_IDLE) ? '0 : flush_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (i_flush) state_nxt = ST_FLUSH;
         ST_FLUSH: if (flush_cnt == IDX_W'(NUM_SETS - 1)) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state == ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)
         entry <= '0;
      else if (state == ST_FLUSH)
         entry[flush_cnt] <= '0;
      else if (upd_acc)
         entry[i_upd_index] <= upd_new;
   end

   assign vld_pipe[0]     = rd_acc;
   assign o_sa_data_valid = vld_pipe[1];

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         vld_pipe[1] <= 1'b0;
         o_sa_data   <= '0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         if (rd_acc) o_sa_data <= rd_hit ? upd_new : entry[i_rd_index];
      end
   end
endmodule
